// File: rtl/spi_sram_pkg.sv
// Shared constants and FSM state type for the SPI SRAM responder.
// Used by spi_pin_sync and spi_sram_responder.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int ADDR_PHASE_BITS   = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD,
    WR,
    IGNORE
  } state_e;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus sclk edge strobes.
// Slave select resets high so a reset never looks like a frame start.
module spi_pin_sync
  import spi_sram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_s,
  output logic mosi_s
);

  logic [2:0] sclk_q, sclk_d;
  logic [1:0] ss_q, ss_d;
  logic [1:0] mosi_q, mosi_d;

  // shift each pin into its synchroniser chain
  always_comb begin
    sclk_d = {sclk_q[1:0], sclk};
    ss_d   = {ss_q[0], ss};
    mosi_d = {mosi_q[0], mosi};
  end

  // synchroniser flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= '0;
      ss_q   <= 2'b11;
      mosi_q <= '0;
    end else begin
      sclk_q <= sclk_d;
      ss_q   <= ss_d;
      mosi_q <= mosi_d;
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_s      = ss_q[1];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave fronting a byte-wide local memory (READ 03 / WRITE 02).
// SPI_SRAM_WRITE_PROTECT_EN adds an active-low wp input that blocks writes.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss,
  input  logic mosi,
`ifdef SPI_SRAM_WRITE_PROTECT_EN
  input  logic wp,
`endif
  output logic miso,
  output logic miso_oe,
  output logic wr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic sclk_rise, sclk_fall, ss_s, mosi_s;

  spi_pin_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_s      (ss_s),
    .mosi_s    (mosi_s)
  );

  logic wp_ok;

`ifdef SPI_SRAM_WRITE_PROTECT_EN
  logic [1:0] wp_q, wp_d;

  // wp synchroniser input
  always_comb wp_d = {wp_q[0], wp};

  // wp synchroniser flops; protected until the pin is seen high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wp_q <= '0;
    else      wp_q <= wp_d;
  end

  assign wp_ok = wp_q[1];
`else
  assign wp_ok = 1'b1;
`endif

  state_e state_q, state_d;

  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [14:0]       sh_in_q, sh_in_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              wr_done_q, wr_done_d;
  logic              mem_we;
  logic [7:0]        mem_wdata;

  logic [7:0] mem [DEPTH];

  logic              rise_ok, fall_ok;
  logic              last_byte_bit, last_addr_bit;
  logic [7:0]        byte_in;
  logic [15:0]       addr_in;
  logic [ADDR_W-1:0] addr_load, addr_nxt;

  // ss going high outranks any sclk strobe seen in the same cycle
  assign rise_ok       = sclk_rise & ~ss_s;
  assign fall_ok       = sclk_fall & ~ss_s;
  assign last_byte_bit = bit_cnt_q == 4'd7;
  assign last_addr_bit = bit_cnt_q == 4'(ADDR_PHASE_BITS - 1);
  assign byte_in       = {sh_in_q[6:0], mosi_s};
  assign addr_in       = {sh_in_q, mosi_s};
  assign addr_load     = ADDR_W'(addr_in);
  assign addr_nxt      = addr_q + ADDR_W'(1);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (ss_s) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (rise_ok && last_byte_bit)
            state_d = cmd_known(byte_in) ? ADDR : IGNORE;
        end
        ADDR: begin
          if (rise_ok && last_addr_bit)
            state_d = rd_q ? RD : WR;
        end
        RD, WR, IGNORE: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  // datapath and output logic
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sh_in_d   = sh_in_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    wr_done_d = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = byte_in;
    if (ss_s) begin
      bit_cnt_d = '0;
      sh_in_d   = '0;
      tx_d      = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      if (rise_ok) begin
        sh_in_d   = {sh_in_q[13:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      unique case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          sh_in_d   = '0;
        end
        CMD: begin
          if (rise_ok && last_byte_bit) begin
            bit_cnt_d = '0;
            rd_d      = byte_in == CMD_READ;
          end
        end
        ADDR: begin
          if (rise_ok && last_addr_bit) begin
            bit_cnt_d = '0;
            addr_d    = addr_load;
            if (rd_q) tx_d = mem[addr_load];
          end
        end
        WR: begin
          if (rise_ok && last_byte_bit) begin
            bit_cnt_d = '0;
            addr_d    = addr_nxt;
            if (wp_ok) begin
              mem_we    = 1'b1;
              wr_done_d = 1'b1;
            end
          end
        end
        RD: begin
          if (rise_ok && last_byte_bit) begin
            bit_cnt_d = '0;
            addr_d    = addr_nxt;
            tx_d      = mem[addr_nxt];
          end
          if (fall_ok) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
            oe_d   = 1'b1;
          end
        end
        IGNORE: bit_cnt_d = '0;
        default: bit_cnt_d = '0;
      endcase
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q <= '0;
      sh_in_q   <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sh_in_q   <= sh_in_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      wr_done_q <= wr_done_d;
    end
  end

  // memory array write port, contents not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
  end

  assign miso    = miso_q;
  assign miso_oe = oe_q;
  assign wr_done = wr_done_q;

endmodule
